// File: rtl/fix_pkg.sv
// Shared constants and FSM state type for the FIX field serializer.
package fix_pkg;

   localparam logic [7:0] FIX_SOH     = 8'h01;
   localparam logic [7:0] FIX_EQ      = 8'h3D;
   localparam logic [7:0] FIX_ZERO    = 8'h30;
   localparam logic [7:0] FIX_CK_TAG0 = 8'h31;
   localparam logic [7:0] FIX_CK_TAG1 = 8'h30;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_TAG,
      ST_EQ,
      ST_VAL,
      ST_SOH,
      ST_CK_TAG,
      ST_CK_D2,
      ST_CK_D1,
      ST_CK_D0,
      ST_CK_SOH
   } ser_state_t;

endpackage

// File: rtl/fix_chksum_ascii.sv
// Converts an 8-bit checksum into three ASCII decimal digits using compare/subtract steps.
module fix_chksum_ascii
   import fix_pkg::*;
(
   input  logic [7:0] value_i,
   output logic [7:0] d2_o,
   output logic [7:0] d1_o,
   output logic [7:0] d0_o
);

   logic [7:0] rem;
   logic [1:0] hund;
   logic [3:0] tens;

   always_comb begin
      rem  = value_i;
      hund = 2'd0;
      tens = 4'd0;
      if (rem >= 8'd200) begin
         rem  = rem - 8'd200;
         hund = 2'd2;
      end else if (rem >= 8'd100) begin
         rem  = rem - 8'd100;
         hund = 2'd1;
      end
      // remainder is below 100 here, so nine conditional subtractions suffice
      for (int k = 0; k < 9; k++) begin
         if (rem >= 8'd10) begin
            rem  = rem - 8'd10;
            tens = tens + 4'd1;
         end
      end
      d2_o = FIX_ZERO + {6'd0, hund};
      d1_o = FIX_ZERO + {4'd0, tens};
      d0_o = FIX_ZERO + rem;
   end

endmodule

// File: rtl/fix_msg_serializer.sv
// Serializes (tag, value) descriptors into "tag=value<SOH>" bytes and appends the
// "10=ddd<SOH>" trailer on the last field, with valid/ready on both sides.
module fix_msg_serializer
   import fix_pkg::*;
#(
   parameter int TAG_BYTES = 4,
   parameter int VAL_BYTES = 32,
   parameter int TLEN_W    = $clog2(TAG_BYTES + 1),
   parameter int VLEN_W    = $clog2(VAL_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fld_valid_i,
   output logic                   fld_ready_o,
   input  logic [8*TAG_BYTES-1:0] fld_tag_i,
   input  logic [TLEN_W-1:0]      fld_tag_len_i,
   input  logic [8*VAL_BYTES-1:0] fld_val_i,
   input  logic [VLEN_W-1:0]      fld_val_len_i,
   input  logic                   fld_last_i,
   output logic [7:0]             byte_o,
   output logic                   byte_valid_o,
   input  logic                   byte_ready_i,
   output logic                   byte_sof_o,
   output logic                   byte_eof_o,
   output logic                   msg_done_o,
   output logic [7:0]             chksum_o,
   output logic                   err_o
);

   localparam int IDX_W = (TLEN_W > VLEN_W) ? TLEN_W : VLEN_W;

   ser_state_t             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [8*TAG_BYTES-1:0] tag_q, tag_d;
   logic [8*VAL_BYTES-1:0] val_q, val_d;
   logic [TLEN_W-1:0]      tlen_q, tlen_d;
   logic [VLEN_W-1:0]      vlen_q, vlen_d;
   logic                   last_q, last_d;
   logic [7:0]             byte_q, byte_d;
   logic                   valid_q, valid_d;
   logic                   sof_q, sof_d;
   logic                   eof_q, eof_d;
   logic                   sof_pend_q, sof_pend_d;
   logic [7:0]             acc_q, acc_d;
   logic [7:0]             frozen_q, frozen_d;
   logic [7:0]             chksum_q, chksum_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   ready_q, ready_d;

   logic                   hs;
   logic                   fld_illegal;
   logic [IDX_W-1:0]       idx_inc;
   logic [IDX_W-1:0]       tlen_last;
   logic [IDX_W-1:0]       vlen_last;
   logic [7:0]             ck_d2, ck_d1, ck_d0;

   assign hs          = valid_q && byte_ready_i;
   assign fld_illegal = (fld_tag_len_i == '0) || (int'(fld_tag_len_i) > TAG_BYTES) ||
                        (fld_val_len_i == '0) || (int'(fld_val_len_i) > VAL_BYTES);
   assign idx_inc     = idx_q + IDX_W'(1);
   assign tlen_last   = IDX_W'(tlen_q) - IDX_W'(1);
   assign vlen_last   = IDX_W'(vlen_q) - IDX_W'(1);

   fix_chksum_ascii u_ascii (
      .value_i (frozen_q),
      .d2_o    (ck_d2),
      .d1_o    (ck_d1),
      .d0_o    (ck_d0)
   );

   // byte_q always holds the byte belonging to state_q; a handshake loads the next one
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tag_d      = tag_q;
      val_d      = val_q;
      tlen_d     = tlen_q;
      vlen_d     = vlen_q;
      last_d     = last_q;
      byte_d     = byte_q;
      valid_d    = valid_q;
      sof_d      = sof_q;
      eof_d      = eof_q;
      sof_pend_d = sof_pend_q;
      acc_d      = acc_q;
      frozen_d   = frozen_q;
      chksum_d   = chksum_q;
      ready_d    = ready_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      if (hs) begin
         sof_d      = 1'b0;
         sof_pend_d = 1'b0;
         if (state_q inside {ST_TAG, ST_EQ, ST_VAL, ST_SOH})
            acc_d = acc_q + byte_q;
      end

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (fld_valid_i && ready_q) begin
               tag_d  = fld_tag_i;
               val_d  = fld_val_i;
               tlen_d = fld_tag_len_i;
               vlen_d = fld_val_len_i;
               last_d = fld_last_i;
               idx_d  = '0;
               if (!fld_illegal) begin
                  state_d = ST_TAG;
                  byte_d  = fld_tag_i[7:0];
                  valid_d = 1'b1;
                  sof_d   = sof_pend_q;
                  ready_d = 1'b0;
               end else begin
                  err_d = 1'b1;
                  if (fld_last_i) begin
                     state_d  = ST_CK_TAG;
                     byte_d   = FIX_CK_TAG0;
                     valid_d  = 1'b1;
                     sof_d    = sof_pend_q;
                     frozen_d = acc_q;
                     ready_d  = 1'b0;
                  end
               end
            end
         end
         ST_TAG: if (hs) begin
            if (idx_q == tlen_last) begin
               state_d = ST_EQ;
               byte_d  = FIX_EQ;
               idx_d   = '0;
            end else begin
               idx_d  = idx_inc;
               byte_d = tag_q[8*idx_inc +: 8];
            end
         end
         ST_EQ: if (hs) begin
            state_d = ST_VAL;
            byte_d  = val_q[7:0];
            idx_d   = '0;
         end
         ST_VAL: if (hs) begin
            if (idx_q == vlen_last) begin
               state_d = ST_SOH;
               byte_d  = FIX_SOH;
            end else begin
               idx_d  = idx_inc;
               byte_d = val_q[8*idx_inc +: 8];
            end
         end
         ST_SOH: if (hs) begin
            if (last_q) begin
               state_d  = ST_CK_TAG;
               byte_d   = FIX_CK_TAG0;
               idx_d    = '0;
               frozen_d = acc_d;
            end else begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               ready_d = 1'b1;
            end
         end
         ST_CK_TAG: if (hs) begin
            idx_d = idx_inc;
            if (idx_q == IDX_W'(0)) begin
               byte_d = FIX_CK_TAG1;
            end else if (idx_q == IDX_W'(1)) begin
               byte_d = FIX_EQ;
            end else begin
               state_d = ST_CK_D2;
               byte_d  = ck_d2;
            end
         end
         ST_CK_D2: if (hs) begin
            state_d = ST_CK_D1;
            byte_d  = ck_d1;
         end
         ST_CK_D1: if (hs) begin
            state_d = ST_CK_D0;
            byte_d  = ck_d0;
         end
         ST_CK_D0: if (hs) begin
            state_d = ST_CK_SOH;
            byte_d  = FIX_SOH;
            eof_d   = 1'b1;
         end
         ST_CK_SOH: if (hs) begin
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            eof_d      = 1'b0;
            ready_d    = 1'b1;
            chksum_d   = frozen_q;
            acc_d      = 8'd0;
            done_d     = 1'b1;
            sof_pend_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         tag_q      <= '0;
         val_q      <= '0;
         tlen_q     <= '0;
         vlen_q     <= '0;
         last_q     <= 1'b0;
         byte_q     <= 8'd0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         sof_pend_q <= 1'b1;
         acc_q      <= 8'd0;
         frozen_q   <= 8'd0;
         chksum_q   <= 8'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tag_q      <= tag_d;
         val_q      <= val_d;
         tlen_q     <= tlen_d;
         vlen_q     <= vlen_d;
         last_q     <= last_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         sof_pend_q <= sof_pend_d;
         acc_q      <= acc_d;
         frozen_q   <= frozen_d;
         chksum_q   <= chksum_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
      end
   end

   assign fld_ready_o  = ready_q;
   assign byte_o       = byte_q;
   assign byte_valid_o = valid_q;
   assign byte_sof_o   = sof_q;
   assign byte_eof_o   = eof_q;
   assign msg_done_o   = done_q;
   assign chksum_o     = chksum_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_fix_msg_serializer.sv
// Directed bench for fix_msg_serializer: vector table of complete messages plus
// hand-written sequences for backpressure, illegal lengths, reset and maximum lengths.
module tb_fix_msg_serializer;

   localparam int TB_TAG = 4;
   localparam int TB_VAL = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           fld_valid_i;
   logic           fld_ready_o;
   logic [31:0]    fld_tag_i;
   logic [2:0]     fld_tag_len_i;
   logic [255:0]   fld_val_i;
   logic [5:0]     fld_val_len_i;
   logic           fld_last_i;
   logic [7:0]     byte_o;
   logic           byte_valid_o;
   logic           byte_ready_i;
   logic           byte_sof_o;
   logic           byte_eof_o;
   logic           msg_done_o;
   logic [7:0]     chksum_o;
   logic           err_o;

   always #5 clk = ~clk;

   fix_msg_serializer #(.TAG_BYTES(TB_TAG), .VAL_BYTES(TB_VAL)) dut (
      .clk           (clk),
      .rst           (rst),
      .fld_valid_i   (fld_valid_i),
      .fld_ready_o   (fld_ready_o),
      .fld_tag_i     (fld_tag_i),
      .fld_tag_len_i (fld_tag_len_i),
      .fld_val_i     (fld_val_i),
      .fld_val_len_i (fld_val_len_i),
      .fld_last_i    (fld_last_i),
      .byte_o        (byte_o),
      .byte_valid_o  (byte_valid_o),
      .byte_ready_i  (byte_ready_i),
      .byte_sof_o    (byte_sof_o),
      .byte_eof_o    (byte_eof_o),
      .msg_done_o    (msg_done_o),
      .chksum_o      (chksum_o),
      .err_o         (err_o)
   );

   typedef struct packed {
      logic [31:0]  tag;
      logic [2:0]   tlen;
      logic [255:0] val;
      logic [5:0]   vlen;
      logic         last;
      logic [95:0]  exp;     // expected stream, first byte in the most significant used byte
      logic [7:0]   exp_n;
      logic [7:0]   exp_ck;
   } vec_t;

   vec_t vecs [5];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0] cap_b   [$];
   logic       cap_sof [$];
   logic       cap_eof [$];
   int         cap_cyc [$];
   logic [7:0] exp_b   [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && byte_valid_o && byte_ready_i) begin
         cap_b.push_back(byte_o);
         cap_sof.push_back(byte_sof_o);
         cap_eof.push_back(byte_eof_o);
         cap_cyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_caps();
      cap_b.delete();
      cap_sof.delete();
      cap_eof.delete();
      cap_cyc.delete();
      exp_b.delete();
   endtask

   task automatic send_field(input logic [31:0] tag, input logic [2:0] tlen,
                             input logic [255:0] val, input logic [5:0] vlen,
                             input logic last);
      int t;
      t = 0;
      while (fld_ready_o !== 1'b1 && t < 400) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 400) chk("ready_timeout", fld_ready_o, 1);
      fld_valid_i   = 1'b1;
      fld_tag_i     = tag;
      fld_tag_len_i = tlen;
      fld_val_i     = val;
      fld_val_len_i = vlen;
      fld_last_i    = last;
      @(posedge clk);
      #1;
      // scramble the descriptor to prove it was captured
      fld_valid_i   = 1'b0;
      fld_tag_i     = '1;
      fld_tag_len_i = '1;
      fld_val_i     = '1;
      fld_val_len_i = '1;
      fld_last_i    = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (t < 400) begin
         @(posedge clk);
         #1;
         t++;
         if (msg_done_o === 1'b1) break;
      end
      if (t >= 400) chk("done_timeout", msg_done_o, 1);
   endtask

   task automatic model_field(input logic [31:0] tag, input int tlen,
                              input logic [255:0] val, input int vlen);
      for (int k = 0; k < tlen; k++) exp_b.push_back(tag[8*k +: 8]);
      exp_b.push_back(8'h3D);
      for (int k = 0; k < vlen; k++) exp_b.push_back(val[8*k +: 8]);
      exp_b.push_back(8'h01);
   endtask

   // returns the checksum it appended
   task automatic model_trailer(output logic [7:0] ck);
      int s;
      s = 0;
      foreach (exp_b[i]) s += int'(exp_b[i]);
      s = s % 256;
      ck = 8'(s);
      exp_b.push_back(8'h31);
      exp_b.push_back(8'h30);
      exp_b.push_back(8'h3D);
      exp_b.push_back(8'(8'h30 + s / 100));
      exp_b.push_back(8'(8'h30 + (s / 10) % 10));
      exp_b.push_back(8'(8'h30 + s % 10));
      exp_b.push_back(8'h01);
   endtask

   task automatic compare_stream(input string name);
      int n;
      n = exp_b.size();
      chk({name, "_count"}, cap_b.size(), n);
      for (int i = 0; i < n && i < cap_b.size(); i++) begin
         chk($sformatf("%s_byte%0d", name, i), cap_b[i], exp_b[i]);
         chk($sformatf("%s_sof%0d", name, i), cap_sof[i], (i == 0) ? 1 : 0);
         chk($sformatf("%s_eof%0d", name, i), cap_eof[i], (i == n - 1) ? 1 : 0);
      end
   endtask

   task automatic run_vec(input int id, input vec_t v);
      logic ill;
      clear_caps();
      for (int k = 0; k < int'(v.exp_n); k++)
         exp_b.push_back(v.exp[8*(int'(v.exp_n) - 1 - k) +: 8]);
      ill = (v.tlen == 0) || (v.tlen > 3'(TB_TAG)) || (v.vlen == 0) || (v.vlen > 6'(TB_VAL));
      send_field(v.tag, v.tlen, v.val, v.vlen, v.last);
      chk($sformatf("v%0d_lat_valid", id), byte_valid_o, 1);
      chk($sformatf("v%0d_lat_byte", id), byte_o, exp_b[0]);
      chk($sformatf("v%0d_ready_low", id), fld_ready_o, 0);
      chk($sformatf("v%0d_err", id), err_o, ill);
      wait_done();
      chk($sformatf("v%0d_chksum", id), chksum_o, v.exp_ck);
      chk($sformatf("v%0d_ready_back", id), fld_ready_o, 1);
      compare_stream($sformatf("v%0d", id));
      $display("txn vec %0d: %0d bytes captured, chksum_o=%02h", id, cap_b.size(), chksum_o);
   endtask

   initial begin
      logic [7:0]   ck;
      logic [7:0]   held;
      logic [255:0] bigval;
      int           t;
      int           n_before;

      vecs[0] = '{tag: 32'h3533, tlen: 3'd2, val: 256'h41, vlen: 6'd1, last: 1'b1,
                  exp: 96'h33353D410131303D32333101, exp_n: 8'd12, exp_ck: 8'hE7};
      vecs[1] = '{tag: 32'h7F, tlen: 3'd1, val: 256'h43, vlen: 6'd1, last: 1'b1,
                  exp: 96'h7F3D430131303D30303001, exp_n: 8'd11, exp_ck: 8'h00};
      vecs[2] = '{tag: 32'h39, tlen: 3'd1, val: 256'h3231, vlen: 6'd2, last: 1'b1,
                  exp: 96'h393D313201_31303D32313801, exp_n: 8'd12, exp_ck: 8'hDA};
      vecs[3] = '{tag: 32'h3533, tlen: 3'd5, val: 256'h41, vlen: 6'd1, last: 1'b1,
                  exp: 96'h31303D30303001, exp_n: 8'd7, exp_ck: 8'h00};
      vecs[4] = '{tag: 32'h3533, tlen: 3'd2, val: 256'h41, vlen: 6'd0, last: 1'b1,
                  exp: 96'h31303D30303001, exp_n: 8'd7, exp_ck: 8'h00};

      rst           = 1'b1;
      fld_valid_i   = 1'b0;
      fld_tag_i     = '0;
      fld_tag_len_i = '0;
      fld_val_i     = '0;
      fld_val_len_i = '0;
      fld_last_i    = 1'b0;
      byte_ready_i  = 1'b1;

      // reset state
      #1;
      chk("rst_ready", fld_ready_o, 0);
      chk("rst_valid", byte_valid_o, 0);
      chk("rst_byte", byte_o, 0);
      chk("rst_sof", byte_sof_o, 0);
      chk("rst_eof", byte_eof_o, 0);
      chk("rst_done", msg_done_o, 0);
      chk("rst_chksum", chksum_o, 0);
      chk("rst_err", err_o, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_ready", fld_ready_o, 1);
      $display("txn reset: fld_ready_o=%0b", fld_ready_o);

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // multi-field message with a 3-cycle stall in the middle of the first value
      clear_caps();
      model_field(32'h38, 1, 256'h322E342E584946, 7);
      model_field(32'h3533, 2, 256'h30, 1);
      model_trailer(ck);
      send_field(32'h38, 3'd1, 256'h322E342E584946, 6'd7, 1'b0);
      t = 0;
      while (cap_b.size() < 4 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      held = byte_o;
      byte_ready_i = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold_byte%0d", s), byte_o, held);
         chk($sformatf("bp_hold_valid%0d", s), byte_valid_o, 1);
      end
      byte_ready_i = 1'b1;
      send_field(32'h3533, 3'd2, 256'h30, 6'd1, 1'b1);
      wait_done();
      chk("bp_chksum", chksum_o, ck);
      compare_stream("bp");
      $display("txn backpressure: %0d bytes captured, chksum_o=%02h", cap_b.size(), chksum_o);

      // illegal non-last field between two legal fields leaves the checksum untouched
      clear_caps();
      model_field(32'h38, 1, 256'h58, 1);
      model_field(32'h39, 1, 256'h31, 1);
      model_trailer(ck);
      send_field(32'h38, 3'd1, 256'h58, 6'd1, 1'b0);
      t = 0;
      while (fld_ready_o !== 1'b1 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      n_before = cap_b.size();
      send_field(32'h39, 3'd0, 256'h31, 6'd1, 1'b0);
      chk("ill_err_pulse", err_o, 1);
      chk("ill_ready", fld_ready_o, 1);
      chk("ill_no_valid", byte_valid_o, 0);
      @(posedge clk);
      #1;
      chk("ill_err_clear", err_o, 0);
      chk("ill_no_bytes", cap_b.size(), n_before);
      send_field(32'h39, 3'd1, 256'h31, 6'd1, 1'b1);
      wait_done();
      chk("ill_chksum", chksum_o, ck);
      compare_stream("ill");
      $display("txn illegal: %0d bytes captured, chksum_o=%02h", cap_b.size(), chksum_o);

      // asynchronous reset in the middle of a value
      clear_caps();
      send_field(32'h38, 3'd1, 256'h322E342E584946, 6'd7, 1'b1);
      t = 0;
      while (cap_b.size() < 4 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", byte_valid_o, 0);
      chk("arst_byte", byte_o, 0);
      chk("arst_sof", byte_sof_o, 0);
      chk("arst_ready", fld_ready_o, 0);
      chk("arst_chksum", chksum_o, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      $display("txn async reset: byte_valid_o=%0b chksum_o=%02h", byte_valid_o, chksum_o);
      run_vec(10, vecs[0]);

      // maximum tag and value lengths, no gap cycles
      clear_caps();
      bigval = '0;
      for (int k = 0; k < TB_VAL; k++) bigval[8*k +: 8] = 8'(8'h41 + k);
      model_field(32'h34333231, TB_TAG, bigval, TB_VAL);
      model_trailer(ck);
      send_field(32'h34333231, 3'd4, bigval, 6'd32, 1'b1);
      wait_done();
      chk("max_chksum", chksum_o, ck);
      compare_stream("max");
      if (cap_cyc.size() == exp_b.size())
         chk("max_no_gap", cap_cyc[cap_cyc.size() - 1] - cap_cyc[0], exp_b.size() - 1);
      $display("txn max length: %0d bytes captured, chksum_o=%02h", cap_b.size(), chksum_o);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fix_msg_serializer.md
# fix_msg_serializer

Parametrised FIX field serializer that turns (tag, value) field descriptors into the FIX wire byte stream `tag '=' value SOH`. On the last field of a message it appends the standard trailer `10=ddd SOH`, where `ddd` is the running checksum computed internally. It replaces the fixed-width tag/value byte emitter and its external checksum block, and adds valid/ready handshakes on both sides. It sits between the message builder and the transmit MAC/FIFO.

## Interface
- `TAG_BYTES`, default 4: maximum tag length in bytes.
- `VAL_BYTES`, default 32: maximum value length in bytes.
- `TLEN_W`, default `$clog2(TAG_BYTES+1)`: width of the tag-length field.
- `VLEN_W`, default `$clog2(VAL_BYTES+1)`: width of the value-length field.
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `fld_valid_i` input 1: field descriptor valid.
- `fld_ready_o` output 1: block can accept a field.
- `fld_tag_i` input 8*TAG_BYTES: tag ASCII bytes; byte k is at [8k+:8], and byte 0 is sent first.
- `fld_tag_len_i` input TLEN_W: number of tag bytes, legal range 1..TAG_BYTES.
- `fld_val_i` input 8*VAL_BYTES: value bytes, same ordering as the tag.
- `fld_val_len_i` input VLEN_W: number of value bytes, legal range 1..VAL_BYTES.
- `fld_last_i` input 1: append the checksum trailer after this field.
- `byte_o` output 8: serialized byte.
- `byte_valid_o` output 1: `byte_o` is valid.
- `byte_ready_i` input 1: downstream accepts the byte.
- `byte_sof_o` output 1: qualifies the first byte of a message.
- `byte_eof_o` output 1: qualifies the trailer SOH byte.
- `msg_done_o` output 1: one-cycle pulse on the trailer SOH handshake.
- `chksum_o` output 8: checksum of the last completed message.
- `err_o` output 1: one-cycle pulse when a field with an illegal length is accepted.

## Operation
- **Field acceptance:** a field is accepted when `fld_valid_i && fld_ready_o`. The descriptor is captured into internal registers, so the inputs may change after acceptance.
- **Output bytes:** a byte transfers when `byte_valid_o && byte_ready_i`. While `byte_valid_o` is high and `byte_ready_i` is low, `byte_o`, `byte_sof_o` and `byte_eof_o` hold stable.
- **State machine:**
  - IDLE -> TAG on acceptance of a legal field.
  - TAG sends tag bytes 0..tlen-1, then -> EQ.
  - EQ sends 0x3D, then -> VAL.
  - VAL sends value bytes 0..vlen-1, then -> SOH.
  - SOH sends 0x01. If the field's last flag is clear -> IDLE; if set -> CK_TAG.
  - CK_TAG sends 0x31, 0x30, 0x3D in that order, then -> CK_D2.
  - CK_D2, CK_D1 and CK_D0 send the ASCII hundreds, tens and ones digits of the checksum, then -> CK_SOH.
  - CK_SOH sends 0x01, then -> IDLE.
- **Advancing:** every state advances only on a byte handshake.
- **Checksum:**
  - It is an 8-bit accumulator, sum mod 256, over every byte sent in TAG, EQ, VAL and SOH since the start of the message.
  - Trailer bytes are excluded.
  - The digits are taken from the accumulator value frozen on entry to CK_TAG; each digit is 0x30 plus the decimal digit, in the range 000..255.
  - On the CK_SOH handshake, `chksum_o` is loaded with the frozen value, the accumulator is cleared, and `msg_done_o` pulses.
- **Illegal lengths:** tag length 0 or greater than TAG_BYTES, or value length 0 or greater than VAL_BYTES.
  - The field is accepted, no field bytes are sent, and `err_o` pulses the cycle after acceptance.
  - If the last flag was set, the FSM goes to CK_TAG and the trailer is still emitted with the current checksum. Otherwise it stays in IDLE.
- **Start of message:** `byte_sof_o` is 1 on the first byte sent after reset or after a trailer SOH.
- **Reset:** reset mid-message aborts the message, drops any partial bytes, and clears the accumulator.

## Timing
- **Reset values:** `fld_ready_o` 0 during reset and 1 after; all other outputs 0. The FSM resets to IDLE and the next byte is marked start-of-message.
- **Ready:** `fld_ready_o` is 1 only in IDLE. It is registered and deasserts the cycle after acceptance.
- **Latency:** the first tag byte of an accepted field appears on `byte_o` the cycle after acceptance.
- **Throughput:** one byte per cycle with `byte_ready_i` held high. A field occupies tlen+vlen+2 byte cycles plus 1 IDLE acceptance cycle; the trailer adds 7 byte cycles.
- **Return to IDLE:** `fld_ready_o` reasserts the cycle after the SOH (or trailer SOH) handshake.
- **Error path:** an illegal non-last field returns `fld_ready_o` high 1 cycle after acceptance.
- **Registered outputs:** all outputs are registered; there is no combinational path from `byte_ready_i` to `byte_o`.

## Structure
- **Package `fix_pkg`:**
  - ASCII constants `FIX_SOH` 8'h01, `FIX_EQ` 8'h3D, `FIX_ZERO` 8'h30.
  - Checksum tag bytes 8'h31, 8'h30.
  - FSM state enum `ser_state_t`.
- **Sub-module `fix_chksum_ascii`:** combinational conversion of an 8-bit value to three ASCII digits using compare/subtract; no divider.
- **Byte selection:** a byte index counter of width max(TLEN_W, VLEN_W) drives a dynamic part-select on the captured tag/value registers.

## Test plan
- **Single field:** tag "35", len 2; value "A", len 1; last=1; ready held high. Output must be 33 35 3D 41 01 31 30 3D 32 33 31 01, i.e. checksum 231 sent as "231". `byte_sof_o` on the first byte, `byte_eof_o` on the last; `msg_done_o` pulses and `chksum_o` = 0xE7.
- **Checksum wrap:** tag 0x7F len 1, value 0x43 len 1, last=1. The sum is 0x100, so the trailer digits must be 30 30 30 and `chksum_o` = 0x00.
- **Multi-field backpressure:** field "8"="FIX.4.2" with last=0, then "35"="0" with last=1. Drop `byte_ready_i` for 3 cycles mid-value. `byte_o` must hold stable, no bytes may be lost or duplicated, and the checksum must match a software model.
- **Illegal length:** tag_len=0 with last=0. `err_o` pulses, no bytes are sent, `fld_ready_o` returns the next cycle, and the accumulator is unchanged.
- **Reset mid-message:** assert `rst` asynchronously during VAL. Outputs go to 0 immediately. A following single-field message must show `byte_sof_o` and a checksum computed from zero.
- **Maximum lengths:** TAG_BYTES-byte tag and VAL_BYTES-byte value. All bytes must appear in order, byte 0 first, with no gap cycles while `byte_ready_i` is held high.
